// File: rtl/alu_issue.sv
// Request FIFO plus issue sequencer that drives the ALU operand registers and returns results.
// Latency: request accepted in cycle 0, operands on ALUControl/rs/rt in cycle 2, rsp_valid in cycle 3.
// Backpressure: req_ready low at DEPTH pending; a held response stalls issue until rsp_ready.

// Generic single-clock FIFO: registered occupancy, no write-to-read bypass.
module alu_issue_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign pop_dat = mem[rd_ptr];

  // Storage is never reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module alu_issue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_op,
  input  logic [WIDTH-1:0]         req_a,
  input  logic [WIDTH-1:0]         req_b,
  output logic [3:0]               ALUControl,
  output logic [WIDTH-1:0]         rs,
  output logic [WIDTH-1:0]         rt,
  input  logic [WIDTH-1:0]         ALUresult,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero,
  output logic [$clog2(DEPTH):0]   pending
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  state_t state_nxt;
  logic   fifo_push;
  logic   fifo_pop;
  logic   fifo_empty;
  req_t   push_req;
  req_t   head;

  assign req_ready  = !reset && (pending != FULL_CNT);
  assign fifo_push  = req_valid && req_ready;
  assign fifo_empty = (pending == '0);
  assign push_req   = '{op: req_op, a: req_a, b: req_b};

  alu_issue_fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (push_req),
    .pop      (fifo_pop),
    .pop_dat  (head),
    .count    (pending)
  );

  // Next state and pop decision; RESP can hand straight to EXEC to sustain one op per 2 cycles.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand registers load on pop and otherwise hold; result is captured at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUControl <= '0;
      rs         <= '0;
      rt         <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      if (fifo_pop) begin
        ALUControl <= head.op;
        rs         <= head.a;
        rt         <= head.b;
      end
      if (state == EXEC) begin
        rsp_result <= ALUresult;
        rsp_zero   <= ~|ALUresult;
        rsp_valid  <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed latency/backpressure/reset steps plus a randomized scoreboard run.
module tb_alu_issue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic [2:0]       pending;

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] exp_q[$];

  alu_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .ALUControl (alu_ctl),
    .rs         (rs),
    .rt         (rt),
    .ALUresult  (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .pending    (pending)
  );

  // ALU stub
  assign alu_result = rs + rt + WIDTH'(alu_ctl);

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return a + b + {{(WIDTH-4){1'b0}}, op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic set_req(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  // Drive a random request and record it in the model if it will be accepted this cycle.
  task automatic push_rand(input string tag);
    set_req(1'b1, 4'($urandom), $urandom, $urandom);
    if (req_ready) exp_q.push_back(model(req_op, req_a, req_b));
  endtask

  // Hold rsp_ready high and check n in-order responses, optionally 2 cycles apart.
  task automatic drain(input int n, input bit check_gap);
    int got;
    int last;
    got  = 0;
    last = -1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 60 && got < n; c++) begin
      if (rsp_valid) begin
        if (exp_q.size() > 0) chk("drain_data", rsp_result, exp_q.pop_front());
        else chk("drain_extra", 1, 0);
        if (check_gap && last >= 0) chk("drain_gap", c - last, 2);
        last = c;
        got++;
      end
      step();
    end
    chk("drain_count", got, n);
  endtask

  initial begin
    int accepted;
    int seen;
    logic [WIDTH-1:0] held;
    logic [3:0] b_op;
    logic [WIDTH-1:0] b_a, b_b;

    reset = 1'b1;
    rsp_ready = 1'b0;
    set_req(1'b0, 4'd0, '0, '0);
    step();
    step();
    chk("rst_ctl", alu_ctl, 0);
    chk("rst_rs", rs, 0);
    chk("rst_rt", rt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_pending", pending, 0);
    chk("rst_req_ready", req_ready, 0);

    // Single op: push in cycle 0
    reset = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b1, 4'b1000, 32'd5, 32'd3);
    #1;
    chk("single_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("single_pending_c1", pending, 1);
    step();
    chk("single_ctl_c2", alu_ctl, 4'b1000);
    chk("single_rs_c2", rs, 5);
    chk("single_rt_c2", rt, 3);
    chk("single_valid_c2", rsp_valid, 0);
    step();
    chk("single_valid_c3", rsp_valid, 1);
    chk("single_result_c3", rsp_result, 32'h10);
    chk("single_zero_c3", rsp_zero, 0);
    step();
    chk("single_valid_c4", rsp_valid, 0);

    // Wrap to zero
    set_req(1'b1, 4'd0, 32'd5, 32'hFFFF_FFFB);
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("wrap_valid", rsp_valid, 1);
    chk("wrap_result", rsp_result, 0);
    chk("wrap_zero", rsp_zero, 1);
    step();
    chk("wrap_valid_clear", rsp_valid, 0);

    // Fill with rsp_ready low: six back-to-back offers, five accepted
    rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      if (req_ready) accepted++;
      push_rand("fill");
      step();
    end
    req_valid = 1'b0;
    chk("fill_accepted", accepted, 5);
    chk("fill_pending", pending, 4);
    chk("fill_req_ready", req_ready, 0);
    chk("fill_rsp_valid", rsp_valid, 1);
    chk("fill_first_result", rsp_result, exp_q[0]);
    held = rsp_result;
    step();
    step();
    chk("fill_result_stable", rsp_result, held);
    chk("fill_still_full", req_ready, 0);

    // Drain in order, 2 cycles apart
    drain(5, 1'b1);
    rsp_ready = 1'b0;
    step();
    chk("drain_pending_end", pending, 0);
    chk("drain_valid_end", rsp_valid, 0);
    chk("drain_idle_ready", req_ready, 1);

    // Simultaneous push and pop in RESP with pending = 2
    for (int i = 0; i < 3; i++) begin
      push_rand("sim");
      if (i == 1) begin
        b_op = req_op;
        b_a  = req_a;
        b_b  = req_b;
      end
      step();
    end
    chk("sim_rsp_valid", rsp_valid, 1);
    chk("sim_pending_before", pending, 2);
    chk("sim_first_result", rsp_result, exp_q.pop_front());
    push_rand("sim_d");
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("sim_pending_after", pending, 2);
    chk("sim_exec_ctl", alu_ctl, b_op);
    chk("sim_exec_rs", rs, b_a);
    chk("sim_exec_rt", rt, b_b);
    drain(3, 1'b0);
    rsp_ready = 1'b0;
    step();
    chk("sim_pending_end", pending, 0);

    // Reset during EXEC with 3 queued
    for (int i = 0; i < 5; i++) begin
      push_rand("rst_fill");
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    reset = 1'b1;
    chk("midrst_pending_before", pending, 3);
    chk("midrst_valid_before", rsp_valid, 0);
    exp_q.delete();
    step();
    chk("midrst_ctl", alu_ctl, 0);
    chk("midrst_rs", rs, 0);
    chk("midrst_rt", rt, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_result", rsp_result, 0);
    chk("midrst_rsp_zero", rsp_zero, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_req_ready", req_ready, 0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen++;
      step();
    end
    chk("midrst_no_response", seen, 0);
    chk("midrst_pending_idle", pending, 0);

    // Randomized traffic against the in-order scoreboard
    for (int i = 0; i < 300; i++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) push_rand("rand");
      else req_valid = 1'b0;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() > 0) chk("rand_data", rsp_result, exp_q.pop_front());
        else chk("rand_unexpected_rsp", 1, 0);
      end
      step();
    end
    req_valid = 1'b0;
    drain(exp_q.size(), 1'b0);
    step();
    step();
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_pending_end", pending, 0);
    chk("rand_valid_end", rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Sequencing front end for the combinational ALU. It accepts ALU operation requests over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time on registered `ALUControl`/`rs`/`rt` outputs, captures `ALUresult` one cycle later, and returns it on a valid/ready response port with a zero flag. It is the initiator side of the ALU's `ALUControl`/`rs`/`rt` → `ALUresult` interface, used by multi-cycle datapath control and by ALU self-check benches.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width.
- `DEPTH`, 4, request FIFO entries; power of 2, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request FIFO can accept.
- `req_op`  in  4  ALU operation code, passed unchanged to `ALUControl`.
- `req_a`  in  WIDTH  first operand, to `rs`.
- `req_b`  in  WIDTH  second operand, to `rt`.
- `ALUControl`  out  4  registered op to ALU.
- `rs`  out  WIDTH  registered operand to ALU.
- `rt`  out  WIDTH  registered operand to ALU.
- `ALUresult`  in  WIDTH  combinational ALU result.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_result`  out  WIDTH  captured `ALUresult`.
- `rsp_zero`  out  1  1 when `rsp_result` == 0.
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Request FIFO:
  - Push on `req_valid && req_ready`.
  - `req_ready = !reset && (pending != DEPTH)`.
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - No bypass: a request pushed in cycle N is visible for pop no earlier than cycle N+1.
- FSM states:
  - IDLE: if FIFO non-empty, pop head, load `ALUControl`/`rs`/`rt`, go to EXEC; else stay.
  - EXEC: exactly one cycle. The ALU sees stable registered inputs. At the end of the cycle, latch `rsp_result <= ALUresult`, set `rsp_zero` and `rsp_valid <= 1`, go to RESP.
  - RESP: hold `rsp_*` stable while `!rsp_ready`. On `rsp_ready`:
    - clear `rsp_valid`;
    - if FIFO non-empty in that same cycle, pop the next request into the operand registers and go to EXEC;
    - otherwise go to IDLE.
- Operand registers keep their last value when not loading; they are not cleared after EXEC.
- `pending` tracks pushes and pops:
  - +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - A push can never occur at full, because `req_ready` is low.
- Arithmetic: no computation is done here. `rsp_zero` is the reduction-NOR of the captured WIDTH-bit result.
- Requests are issued strictly in arrival order. Exactly one response is produced per accepted request.

## Timing
- Reset: while `reset` is high at a rising edge, the next state is:
  - `ALUControl = 0`, `rs = 0`, `rt = 0`;
  - `rsp_valid = 0`, `rsp_result = 0`, `rsp_zero = 0`;
  - `pending = 0`, pointers 0, state IDLE.
  - `req_ready = 0` while `reset` is high.
- Reset mid-operation discards FIFO contents, any in-flight EXEC, and any unconsumed response; no response is produced for them.
- Latency, with an empty FIFO and state IDLE:
  - request accepted in cycle 0;
  - operands appear on `ALUControl`/`rs`/`rt` in cycle 2 (EXEC);
  - `rsp_valid` = 1 in cycle 3.
- Throughput: one response per 2 cycles when `rsp_ready` is held high and the FIFO stays non-empty.
- Backpressure:
  - With `rsp_ready` low, at most one response is held, plus DEPTH queued requests.
  - `req_ready` drops in the cycle after the push that fills the FIFO.
- Simultaneous push and pop in RESP with `rsp_ready`: both occur and `pending` is unchanged.

## Test plan
Bench ALU stub: `ALUresult = rs + rt + ALUControl` (mod 2^WIDTH).
- Single op:
  - Stimulus: reset 2 cycles, then push op=4'b1000, a=5, b=3 in cycle 0, `rsp_ready` = 1.
  - Required: in cycle 2, `ALUControl` = 4'b1000, `rs` = 5, `rt` = 3.
  - Required: in cycle 3, `rsp_valid` = 1, `rsp_result` = 0x10, `rsp_zero` = 0; `rsp_valid` = 0 in cycle 4.
- Wrap/zero:
  - Stimulus: op=0, a=5, b=0xFFFFFFFB.
  - Required: `rsp_result` = 0, `rsp_zero` = 1.
- Fill/backpressure:
  - Stimulus: `rsp_ready` = 0; push 6 requests back to back.
  - Required: the first request reaches RESP. `req_ready` goes low once `pending` = 4.
  - Required: exactly 5 requests are accepted and `rsp_result` stays constant.
- Drain order:
  - Stimulus: continue the fill test with `rsp_ready` = 1.
  - Required: 5 responses arrive in push order, spaced 2 cycles apart; `pending` ends at 0 and state returns to IDLE.
- Simultaneous push and pop:
  - Stimulus: `pending` = 2, push in the same cycle as the response handshake.
  - Required: `pending` stays 2 and the next EXEC follows in the next cycle.
- Reset mid-operation:
  - Stimulus: assert `reset` during EXEC with 3 requests queued.
  - Required: next cycle all outputs are 0 and `pending` = 0; no response appears afterward without a new push.
